// File: rtl/timer_pkg.sv
// Shared types and constants for the timer configuration sequencer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned            STEP_W    = 3;
  localparam logic [STEP_W-1:0]      LAST_STEP = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SLVERR  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned TCR_EN_BIT     = 0;
  localparam int unsigned TCR_DIV_EN_BIT = 1;
  localparam int unsigned TCR_DIV_LSB    = 8;

  function automatic logic [31:0] tcr_word(input logic en, input logic div_en,
                                           input logic [3:0] div_val);
    logic [31:0] w;
    w                      = '0;
    w[TCR_EN_BIT]          = en;
    w[TCR_DIV_EN_BIT]      = div_en;
    w[TCR_DIV_LSB +: 4]    = div_val;
    return w;
  endfunction

endpackage

// File: rtl/apb_wr_master.sv
// Single APB write transfer: SETUP/ACCESS handshake with PREADY timeout.
// On success with last=0 it goes straight back to SETUP for the next transfer.
module apb_wr_master
  import timer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       last,
  input  logic       pready,
  input  logic       pslverr,
  output logic       psel,
  output logic       penable,
  output logic       busy,
  output logic       resp_ok,
  output logic       resp_err,
  output logic [1:0] resp_code
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  apb_state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    resp_ok   = 1'b0;
    resp_err  = 1'b0;
    resp_code = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wait_d  = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            resp_err  = 1'b1;
            resp_code = ERR_SLVERR;
            state_d   = ST_IDLE;
          end else begin
            resp_ok = 1'b1;
            state_d = last ? ST_IDLE : ST_SETUP;
          end
        end else if (wait_q == WAIT_LAST) begin
          // wait_q counts completed wait cycles, so this is the TIMEOUT-th ACCESS cycle
          resp_err  = 1'b1;
          resp_code = ERR_TIMEOUT;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign psel    = (state_q != ST_IDLE);
  assign penable = (state_q == ST_ACCESS);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: rtl/timer_cfg_seq.sv
// Timer configuration sequencer: issues the fixed eight-write APB sequence
// that stops, loads, arms and restarts the timer on a single start pulse.
module timer_cfg_seq
  import timer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [11:0] A_TCR   = 12'h000,
  parameter logic [11:0] A_TDR0  = 12'h004,
  parameter logic [11:0] A_TDR1  = 12'h008,
  parameter logic [11:0] A_TCMP0 = 12'h00C,
  parameter logic [11:0] A_TCMP1 = 12'h010,
  parameter logic [11:0] A_TIER  = 12'h014,
  parameter logic [11:0] A_TISR  = 12'h018
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [63:0] cfg_load,
  input  logic [63:0] cfg_cmp,
  input  logic        cfg_div_en,
  input  logic [3:0]  cfg_div_val,
  input  logic        cfg_int_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  err_step,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [11:0] m_paddr,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  logic [63:0]       load_q, cmp_q;
  logic              div_en_q, int_en_q;
  logic [3:0]        div_val_q;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic [11:0]       nxt_addr;
  logic [31:0]       nxt_data;
  logic              accept, last;
  logic              resp_ok, resp_err;
  logic [1:0]        resp_code;

  assign accept = start && !busy;
  assign last   = (step_q == LAST_STEP);

  apb_wr_master #(.TIMEOUT(TIMEOUT)) u_apb (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .req       (accept),
    .last      (last),
    .pready    (m_pready),
    .pslverr   (m_pslverr),
    .psel      (m_psel),
    .penable   (m_penable),
    .busy      (busy),
    .resp_ok   (resp_ok),
    .resp_err  (resp_err),
    .resp_code (resp_code)
  );

  assign m_pwrite = m_psel;
  assign m_pstrb  = {4{m_psel}};

  // Address/data for the step following the current one; step 0 is loaded on accept.
  always_comb begin
    step_nxt = step_q + STEP_W'(1);
    nxt_addr = A_TCR;
    nxt_data = '0;
    case (step_nxt)
      3'd1: begin nxt_addr = A_TDR0;  nxt_data = load_q[31:0];  end
      3'd2: begin nxt_addr = A_TDR1;  nxt_data = load_q[63:32]; end
      3'd3: begin nxt_addr = A_TCMP0; nxt_data = cmp_q[31:0];   end
      3'd4: begin nxt_addr = A_TCMP1; nxt_data = cmp_q[63:32];  end
      3'd5: begin nxt_addr = A_TIER;  nxt_data = {31'b0, int_en_q}; end
      3'd6: begin nxt_addr = A_TISR;  nxt_data = 32'h1; end
      3'd7: begin nxt_addr = A_TCR;   nxt_data = tcr_word(1'b1, div_en_q, div_val_q); end
      default: begin nxt_addr = A_TCR; nxt_data = '0; end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      load_q    <= '0;
      cmp_q     <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
      int_en_q  <= 1'b0;
      step_q    <= '0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      err_step  <= '0;
    end else begin
      done <= resp_ok && last;
      if (accept) begin
        load_q    <= cfg_load;
        cmp_q     <= cfg_cmp;
        div_en_q  <= cfg_div_en;
        div_val_q <= cfg_div_val;
        int_en_q  <= cfg_int_en;
        step_q    <= '0;
        m_paddr   <= A_TCR;
        m_pwdata  <= '0;
        err       <= 1'b0;
        err_code  <= ERR_NONE;
        err_step  <= '0;
      end
      if (resp_ok && !last) begin
        step_q   <= step_nxt;
        m_paddr  <= nxt_addr;
        m_pwdata <= nxt_data;
      end
      if (resp_err) begin
        err      <= 1'b1;
        err_code <= resp_code;
        err_step <= step_q;
      end
    end
  end

endmodule
